rank_index_gen: RTL and testbench

//   Collects a frame of N samples (3x3 window, N=9) from a valid/ready stream and computes

---
 rtl/rank_pkg.sv | 19 +
 rtl/rank_cmp_row.sv | 36 +++
 rtl/rank_index_gen.sv | 138 +++++++++++++
 tb/tb_rank_index_gen.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_pkg.sv
// Shared state encoding, default geometry and slot helper for the rank index generator.
package rank_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RANK = 2'd1,
        ST_OUT  = 2'd2
    } state_e;

    localparam int unsigned DEF_DATA_W = 8;
    localparam int unsigned DEF_N      = 9;
    localparam int unsigned DEF_IDX_W  = 4;

    // LSB position of slot k in a flattened frame of w-bit slots.
    function automatic int unsigned slot_lsb(input int unsigned k, input int unsigned w);
        return k * w;
    endfunction

endpackage

// File: rtl/rank_cmp_row.sv
// Combinational stable rank of one selected slot against every slot of the frame.
module rank_cmp_row
    import rank_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N      = DEF_N,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic [N*DATA_W-1:0] frame_i,
    input  logic [IDX_W-1:0]    sel_i,
    output logic [IDX_W-1:0]    rank_o
);

    logic [DATA_W-1:0] di;
    logic [DATA_W-1:0] dj;

    always_comb begin
        di = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (sel_i == IDX_W'(k)) begin
                di = frame_i[slot_lsb(k, DATA_W) +: DATA_W];
            end
        end

        // Ties are broken by slot order, so the selected slot never counts itself.
        dj     = '0;
        rank_o = '0;
        for (int unsigned j = 0; j < N; j++) begin
            dj = frame_i[slot_lsb(j, DATA_W) +: DATA_W];
            if ((dj < di) || ((dj == di) && (IDX_W'(j) < sel_i))) begin
                rank_o = rank_o + IDX_W'(1);
            end
        end
    end

endmodule

// File: rtl/rank_index_gen.sv
// Frame collector and rank index generator (LOAD -> RANK -> OUT).
// Optional MEDIAN_OUT_EN adds a registered median_out port.
module rank_index_gen
    import rank_pkg::*;
#(
    parameter int unsigned DATA_W = DEF_DATA_W,
    parameter int unsigned N      = DEF_N,
    parameter int unsigned IDX_W  = DEF_IDX_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [DATA_W-1:0]   in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [N*DATA_W-1:0] data_out,
    output logic [N*IDX_W-1:0]  index_out,
    output logic                out_valid,
    input  logic                out_ready,
    output logic                busy
`ifdef MEDIAN_OUT_EN
    ,
    output logic [DATA_W-1:0]   median_out
`endif
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_e               state_q, state_d;
    logic [IDX_W-1:0]     ld_cnt_q, ld_cnt_d;
    logic [IDX_W-1:0]     rk_cnt_q, rk_cnt_d;
    logic [N*DATA_W-1:0]  frame_q;
    logic [N*IDX_W-1:0]   rank_q;
    logic [IDX_W-1:0]     row_rank;
    logic                 accept;

    assign accept = in_valid && in_ready;

    rank_cmp_row #(
        .DATA_W (DATA_W),
        .N      (N),
        .IDX_W  (IDX_W)
    ) u_row (
        .frame_i (frame_q),
        .sel_i   (rk_cnt_q),
        .rank_o  (row_rank)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_LOAD;
            ld_cnt_q <= '0;
            rk_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            rk_cnt_q <= rk_cnt_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        rk_cnt_d = rk_cnt_q;
        case (state_q)
            ST_LOAD: begin
                if (accept) begin
                    if (ld_cnt_q == LAST) begin
                        ld_cnt_d = '0;
                        state_d  = ST_RANK;
                    end else begin
                        ld_cnt_d = ld_cnt_q + IDX_W'(1);
                    end
                end
            end
            ST_RANK: begin
                if (rk_cnt_q == LAST) begin
                    rk_cnt_d = '0;
                    state_d  = ST_OUT;
                end else begin
                    rk_cnt_d = rk_cnt_q + IDX_W'(1);
                end
            end
            ST_OUT: begin
                if (out_ready) begin
                    state_d = ST_LOAD;
                end
            end
            default: state_d = ST_LOAD;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == ST_LOAD);
        out_valid = (state_q == ST_OUT);
        busy      = (state_q != ST_LOAD);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            frame_q <= '0;
            rank_q  <= '0;
        end else begin
            for (int unsigned k = 0; k < N; k++) begin
                if (accept && (ld_cnt_q == IDX_W'(k))) begin
                    frame_q[slot_lsb(k, DATA_W) +: DATA_W] <= in_data;
                end
                if ((state_q == ST_RANK) && (rk_cnt_q == IDX_W'(k))) begin
                    rank_q[slot_lsb(k, IDX_W) +: IDX_W] <= row_rank;
                end
            end
        end
    end

    assign data_out  = frame_q;
    assign index_out = rank_q;

`ifdef MEDIAN_OUT_EN
    localparam logic [IDX_W-1:0] MID = IDX_W'(N / 2);

    logic [DATA_W-1:0] median_q;

    // Exactly one slot per frame carries rank N/2, so this captures once per RANK pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            median_q <= '0;
        end else if ((state_q == ST_RANK) && (row_rank == MID)) begin
            for (int unsigned k = 0; k < N; k++) begin
                if (rk_cnt_q == IDX_W'(k)) begin
                    median_q <= frame_q[slot_lsb(k, DATA_W) +: DATA_W];
                end
            end
        end
    end

    assign median_out = median_q;
`endif

endmodule

// File: tb/tb_rank_index_gen.sv
// Scoreboard bench for rank_index_gen; checks median_out too when MEDIAN_OUT_EN is defined.
module tb_rank_index_gen;

    localparam int unsigned DW = 8;
    localparam int unsigned NS = 9;
    localparam int unsigned IW = 4;

    typedef logic [DW-1:0] frame_t [NS];
    typedef struct {
        logic [NS*DW-1:0] d;
        logic [NS*IW-1:0] r;
        logic [DW-1:0]    m;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst;
    logic [DW-1:0]     in_data;
    logic              in_valid;
    logic              in_ready;
    logic [NS*DW-1:0]  data_out;
    logic [NS*IW-1:0]  index_out;
    logic              out_valid;
    logic              out_ready;
    logic              busy;
`ifdef MEDIAN_OUT_EN
    logic [DW-1:0]     median_out;
`endif

    int   n_total = 0;
    int   n_bad   = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;
    exp_t sb[$];
    exp_t mon_e;

    rank_index_gen #(
        .DATA_W (DW),
        .N      (NS),
        .IDX_W  (IW)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_out  (data_out),
        .index_out (index_out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy)
`ifdef MEDIAN_OUT_EN
        ,
        .median_out(median_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference ranks from a stable insertion sort of slot numbers by value.
    function automatic exp_t model(input frame_t s);
        exp_t        e;
        int unsigned ord [NS];
        int unsigned t;
        int          p;
        for (int i = 0; i < NS; i++) ord[i] = i;
        for (int i = 1; i < NS; i++) begin
            t = ord[i];
            p = i;
            while (p > 0 && s[ord[p-1]] > s[t]) begin
                ord[p] = ord[p-1];
                p--;
            end
            ord[p] = t;
        end
        e.d = '0;
        e.r = '0;
        for (int q = 0; q < NS; q++) begin
            e.d[q*DW +: DW]     = s[q];
            e.r[ord[q]*IW +: IW] = IW'(q);
        end
        e.m = s[ord[NS/2]];
        return e;
    endfunction

    task automatic send_frame(input frame_t s, input bit push, input int max_gap, input int cnt);
        int w;
        if (push) sb.push_back(model(s));
        for (int k = 0; k < cnt; k++) begin
            in_valid = 1'b0;
            in_data  = DW'($urandom);
            repeat ($urandom_range(0, max_gap)) tick();
            in_data  = s[k];
            in_valid = 1'b1;
            w = 0;
            while (!in_ready && w < 100) begin
                tick();
                w++;
            end
            if (w >= 100) check("accept_timeout", 1, 0);
            acc_cyc = cyc;
            tick();
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid();
        int w = 0;
        while (!out_valid && w < 200) begin
            tick();
            w++;
        end
        if (!out_valid) check("valid_timeout", 0, 1);
    endtask

    // Output side of the scoreboard: one pop per out_valid && out_ready handshake.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 1, 0);
            end else begin
                logic [15:0] seen;
                mon_e = sb.pop_front();
                check("data_out", data_out, mon_e.d);
                check("index_out", index_out, mon_e.r);
`ifdef MEDIAN_OUT_EN
                check("median_out", median_out, mon_e.m);
`endif
                seen = '0;
                for (int k = 0; k < NS; k++) seen[index_out[k*IW +: IW]] = 1'b1;
                check("perm", seen, 16'h01FF);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f;
        logic [NS*DW-1:0] snap_d;
        logic [NS*IW-1:0] snap_r;

        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        repeat (3) tick();
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_data_out", data_out, 0);
        check("rst_index_out", index_out, 0);
`ifdef MEDIAN_OUT_EN
        check("rst_median", median_out, 0);
`endif
        rst = 1'b0;
        tick();

        // Descending frame, latency measured from the last accept
        f = '{8'd26, 8'd24, 8'd22, 8'd20, 8'd18, 8'd10, 8'd8, 8'd6, 8'd2};
        send_frame(f, 1, 0, NS);
        check("rank_busy", busy, 1);
        check("rank_in_ready", in_ready, 0);
        wait_valid();
        check("latency", cyc - acc_cyc, 10);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        check("hs_in_ready", in_ready, 1);

        // Ascending frame with out_ready already high
        f = '{8'd2, 8'd6, 8'd8, 8'd10, 8'd18, 8'd20, 8'd22, 8'd24, 8'd26};
        out_ready = 1'b1;
        send_frame(f, 1, 1, NS);
        wait_valid();
        tick();
        check("one_cycle_out", out_valid, 0);

        // All equal: ranks follow slot order
        f = '{default: 8'd5};
        send_frame(f, 1, 0, NS);
        wait_valid();
        tick();
        out_ready = 1'b0;

        // Back-pressure: outputs hold while in_valid pulses are ignored
        f = '{8'd200, 8'd3, 8'd3, 8'd255, 8'd0, 8'd128, 8'd3, 8'd77, 8'd200};
        send_frame(f, 1, 0, NS);
        wait_valid();
        snap_d = data_out;
        snap_r = index_out;
        for (int c = 0; c < 20; c++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_data  = DW'($urandom);
            tick();
            check("hold_data", data_out, snap_d);
            check("hold_index", index_out, snap_r);
            check("hold_valid", out_valid, 1);
            check("hold_in_ready", in_ready, 0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hold_release_valid", out_valid, 0);
        check("hold_release_ready", in_ready, 1);

        // Reset mid-LOAD and mid-RANK
        f = '{8'd9, 8'd1, 8'd4, 8'd7, 8'd3, 8'd8, 8'd2, 8'd6, 8'd5};
        send_frame(f, 0, 0, 4);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_load_in_ready", in_ready, 1);
        check("rst_load_out_valid", out_valid, 0);
        check("rst_load_busy", busy, 0);
        send_frame(f, 0, 0, NS);
        tick();
        tick();
        check("mid_rank_busy", busy, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rst_rank_in_ready", in_ready, 1);
        check("rst_rank_out_valid", out_valid, 0);
        check("rst_rank_index", index_out, 0);
        out_ready = 1'b1;
        send_frame(f, 1, 0, NS);
        wait_valid();
        tick();
        out_ready = 1'b0;

        // Random frames, random input gaps and output stalls
        for (int n = 0; n < 12; n++) begin
            for (int k = 0; k < NS; k++) begin
                f[k] = (n % 2 == 0) ? DW'($urandom_range(0, 7)) : DW'($urandom);
            end
            send_frame(f, 1, 3, NS);
            wait_valid();
            repeat ($urandom_range(0, 5)) tick();
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
        end

        repeat (2) tick();
        check("sb_drain", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
